ii_sii_join: RTL and testbench

II_SII_JOIN -- requirements
Module: ii_sii_join

---
 rtl/ii_sii_join_pkg.sv | 27 ++
 rtl/ii_sii_join_fifo.sv | 59 +++++
 rtl/ii_sii_join.sv | 147 ++++++++++++++
 tb/tb_ii_sii_join.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ii_sii_join_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ii_sii_join_pkg
// Description : Shared constants for the ii/sii stream join block.
//               This file holds the eot bit indices, the default sample
//               widths and a small eot compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ii_sii_join_pkg;

    // Bit positions inside the 2-bit eot field
    localparam int EOT_ROW   = 0;
    localparam int EOT_FRAME = 1;
    localparam int W_EOT     = 2;

    // Default sample widths
    localparam int W_II_DEF  = 18;
    localparam int W_SII_DEF = 26;

    // True when the two streams disagree on their end-of-transfer markers
    function automatic logic eot_mismatch(input logic [W_EOT-1:0] a,
                                          input logic [W_EOT-1:0] b);
        return (a != b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ii_sii_join_fifo.sv
`default_nettype none
// ============================================================================
// Module      : join_fifo
// Description : Small synchronous FIFO, power-of-2 depth. Pointers carry one
//               extra wrap bit so full and empty are told apart without a
//               separate counter. The head is visible combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module join_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Next pointer values; push and pop in the same cycle both advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers, emptied by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/ii_sii_join.sv
`default_nettype none
// ============================================================================
// Module      : ii_sii_join
// Description : Joins an integral-image stream and a squared-integral-image
//               stream into one paired output stream, with per-row pixel and
//               per-frame row counters.
//               Optional macro II_SII_JOIN_EOT_CHECK_EN: stores the sii eot
//               and raises a sticky err_eot_o on eot disagreement.
// Revision    : 1.0 - initial release
// ============================================================================
module ii_sii_join
    import ii_sii_join_pkg::*;
#(
    parameter int W_II       = W_II_DEF,
    parameter int W_SII      = W_SII_DEF,
    parameter int FIFO_DEPTH = 2,
    parameter int W_CNT      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ii_valid_i,
    output logic             ii_ready_o,
    input  logic [W_II-1:0]  ii_data_i,
    input  logic [1:0]       ii_eot_i,
    input  logic             sii_valid_i,
    output logic             sii_ready_o,
    input  logic [W_SII-1:0] sii_data_i,
    input  logic [1:0]       sii_eot_i,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic [W_II-1:0]  dout_ii_o,
    output logic [W_SII-1:0] dout_sii_o,
    output logic [1:0]       dout_eot_o,
    output logic [W_CNT-1:0] pix_cnt_o,
    output logic [W_CNT-1:0] row_cnt_o,
    output logic             err_eot_o
);

`ifdef II_SII_JOIN_EOT_CHECK_EN
    localparam int SII_FW = W_SII + W_EOT;
`else
    localparam int SII_FW = W_SII;
`endif
    localparam int II_FW = W_II + W_EOT;

    logic [II_FW-1:0]  w_ii_din, w_ii_head;
    logic [SII_FW-1:0] w_sii_din, w_sii_head;
    logic              w_ii_full, w_ii_empty, w_sii_full, w_sii_empty;
    logic              w_ii_push, w_sii_push, w_pop;
    logic [1:0]        w_eot;
    logic [W_CNT-1:0]  pix_cnt_q, pix_cnt_d;
    logic [W_CNT-1:0]  row_cnt_q, row_cnt_d;

    // Readies come only from registered FIFO pointers, never from dout_ready_i
    assign ii_ready_o   = !w_ii_full;
    assign sii_ready_o  = !w_sii_full;
    assign w_ii_push    = ii_valid_i  && !w_ii_full;
    assign w_sii_push   = sii_valid_i && !w_sii_full;
    assign dout_valid_o = !w_ii_empty && !w_sii_empty;
    // Both FIFOs always pop together
    assign w_pop        = dout_valid_o && dout_ready_i;

    assign w_ii_din  = {ii_eot_i, ii_data_i};
`ifdef II_SII_JOIN_EOT_CHECK_EN
    assign w_sii_din = {sii_eot_i, sii_data_i};
`else
    logic w_sii_eot_unused;
    assign w_sii_eot_unused = ^sii_eot_i;
    assign w_sii_din = sii_data_i;
`endif

    join_fifo #(.WIDTH(II_FW), .DEPTH(FIFO_DEPTH)) u_ii_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_ii_push),
        .din_i   (w_ii_din),
        .pop_i   (w_pop),
        .dout_o  (w_ii_head),
        .full_o  (w_ii_full),
        .empty_o (w_ii_empty)
    );

    join_fifo #(.WIDTH(SII_FW), .DEPTH(FIFO_DEPTH)) u_sii_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_sii_push),
        .din_i   (w_sii_din),
        .pop_i   (w_pop),
        .dout_o  (w_sii_head),
        .full_o  (w_sii_full),
        .empty_o (w_sii_empty)
    );

    // The ii stream is authoritative for eot
    assign w_eot      = w_ii_head[W_II +: W_EOT];
    assign dout_ii_o  = w_ii_head[W_II-1:0];
    assign dout_sii_o = w_sii_head[W_SII-1:0];
    assign dout_eot_o = w_eot;

    // Counter next state: frame end clears both, row end bumps the row
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        row_cnt_d = row_cnt_q;
        if (w_pop) begin
            if (w_eot[EOT_FRAME]) begin
                pix_cnt_d = '0;
                row_cnt_d = '0;
            end else if (w_eot[EOT_ROW]) begin
                pix_cnt_d = '0;
                row_cnt_d = row_cnt_q + 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers, wrapping naturally at 2^W_CNT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    assign pix_cnt_o = pix_cnt_q;
    assign row_cnt_o = row_cnt_q;

`ifdef II_SII_JOIN_EOT_CHECK_EN
    logic err_eot_q;
    // Sticky flag: set on any transfer whose two eot fields disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_eot_q <= 1'b0;
        end else if (w_pop && eot_mismatch(w_eot, w_sii_head[W_SII +: W_EOT])) begin
            err_eot_q <= 1'b1;
        end
    end
    assign err_eot_o = err_eot_q;
`else
    assign err_eot_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ii_sii_join.sv
`default_nettype none
// ============================================================================
// Module      : tb_ii_sii_join
// Description : Self-checking bench for ii_sii_join: a per-cycle vector table
//               for basic pairing and one-sided stalls, then directed
//               sequences for backpressure, reset, row/frame counting and
//               eot checking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ii_sii_join;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ii_valid = 1'b0, sii_valid = 1'b0, dout_ready = 1'b1;
    logic [17:0] ii_data = '0;
    logic [25:0] sii_data = '0;
    logic [1:0]  ii_eot = '0, sii_eot = '0;
    logic        ii_ready, sii_ready, dout_valid, err_eot;
    logic [17:0] dout_ii;
    logic [25:0] dout_sii;
    logic [1:0]  dout_eot;
    logic [15:0] pix_cnt, row_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef II_SII_JOIN_EOT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    ii_sii_join #(.W_II(18), .W_SII(26), .FIFO_DEPTH(2), .W_CNT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ii_valid_i   (ii_valid),
        .ii_ready_o   (ii_ready),
        .ii_data_i    (ii_data),
        .ii_eot_i     (ii_eot),
        .sii_valid_i  (sii_valid),
        .sii_ready_o  (sii_ready),
        .sii_data_i   (sii_data),
        .sii_eot_i    (sii_eot),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .dout_ii_o    (dout_ii),
        .dout_sii_o   (dout_sii),
        .dout_eot_o   (dout_eot),
        .pix_cnt_o    (pix_cnt),
        .row_cnt_o    (row_cnt),
        .err_eot_o    (err_eot)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated pair: drive, observe head, let it pop, return idle
    task automatic xfer(input logic [17:0] d_ii, input logic [25:0] d_sii,
                        input logic [1:0] e_ii, input logic [1:0] e_sii);
        @(negedge clk);
        ii_valid = 1'b1; ii_data = d_ii; ii_eot = e_ii;
        sii_valid = 1'b1; sii_data = d_sii; sii_eot = e_sii;
        dout_ready = 1'b1;
        @(negedge clk);
        check("xfer_dv", dout_valid, 1'b1);
        check("xfer_ii", dout_ii, d_ii);
        check("xfer_sii", dout_sii, d_sii);
        check("xfer_eot", dout_eot, e_ii);
        ii_valid = 1'b0; sii_valid = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic        iv;
        logic [17:0] id;
        logic        sv;
        logic [25:0] sd;
        logic        dr;
        logic        e_dv;
        logic [17:0] e_ii;
        logic [25:0] e_sii;
        logic        e_ir;
        logic        e_sr;
        logic [15:0] e_pix;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Row: expected state at this negedge, then inputs applied for the next edge
        tbl[0]  = '{"v0_reset",  1'b1, 18'h10, 1'b1, 26'h100, 1'b1, 1'b0, 18'h0,  26'h0,   1'b1, 1'b1, 16'd0};
        tbl[1]  = '{"v1_pair",   1'b0, 18'h0,  1'b0, 26'h0,   1'b1, 1'b1, 18'h10, 26'h100, 1'b1, 1'b1, 16'd0};
        tbl[2]  = '{"v2_popped", 1'b1, 18'h21, 1'b0, 26'h0,   1'b1, 1'b0, 18'h0,  26'h0,   1'b1, 1'b1, 16'd1};
        tbl[3]  = '{"v3_ii1",    1'b1, 18'h22, 1'b0, 26'h0,   1'b1, 1'b0, 18'h0,  26'h0,   1'b1, 1'b1, 16'd1};
        tbl[4]  = '{"v4_iifull", 1'b1, 18'h23, 1'b0, 26'h0,   1'b1, 1'b0, 18'h0,  26'h0,   1'b0, 1'b1, 16'd1};
        tbl[5]  = '{"v5_stall",  1'b1, 18'h23, 1'b0, 26'h0,   1'b1, 1'b0, 18'h0,  26'h0,   1'b0, 1'b1, 16'd1};
        tbl[6]  = '{"v6_stall",  1'b1, 18'h23, 1'b0, 26'h0,   1'b1, 1'b0, 18'h0,  26'h0,   1'b0, 1'b1, 16'd1};
        tbl[7]  = '{"v7_resume", 1'b1, 18'h23, 1'b1, 26'h121, 1'b1, 1'b0, 18'h0,  26'h0,   1'b0, 1'b1, 16'd1};
        tbl[8]  = '{"v8_out21",  1'b1, 18'h23, 1'b1, 26'h122, 1'b1, 1'b1, 18'h21, 26'h121, 1'b0, 1'b1, 16'd1};
        tbl[9]  = '{"v9_out22",  1'b1, 18'h23, 1'b1, 26'h123, 1'b1, 1'b1, 18'h22, 26'h122, 1'b1, 1'b1, 16'd2};
        tbl[10] = '{"v10_out23", 1'b0, 18'h0,  1'b0, 26'h0,   1'b1, 1'b1, 18'h23, 26'h123, 1'b1, 1'b1, 16'd3};
        tbl[11] = '{"v11_empty", 1'b0, 18'h0,  1'b0, 26'h0,   1'b1, 1'b0, 18'h0,  26'h0,   1'b1, 1'b1, 16'd4};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ii_ready", ii_ready, 1'b1);
        check("rst_sii_ready", sii_ready, 1'b1);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_pix", pix_cnt, 16'd0);
        check("rst_row", row_cnt, 16'd0);
        check("rst_err", err_eot, 1'b0);
        rst = 1'b0;

        // Table: single pair, sii stalled for 5 cycles, then resume
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check({tbl[i].name, "_dv"}, dout_valid, tbl[i].e_dv);
            check({tbl[i].name, "_ir"}, ii_ready, tbl[i].e_ir);
            check({tbl[i].name, "_sr"}, sii_ready, tbl[i].e_sr);
            check({tbl[i].name, "_pix"}, pix_cnt, tbl[i].e_pix);
            if (tbl[i].e_dv) begin
                check({tbl[i].name, "_ii"}, dout_ii, tbl[i].e_ii);
                check({tbl[i].name, "_sii"}, dout_sii, tbl[i].e_sii);
                check({tbl[i].name, "_eot"}, dout_eot, 2'b00);
            end
            ii_valid = tbl[i].iv;  ii_data = tbl[i].id;  ii_eot = 2'b00;
            sii_valid = tbl[i].sv; sii_data = tbl[i].sd; sii_eot = 2'b00;
            dout_ready = tbl[i].dr;
        end

        // Output backpressure with both FIFOs full
        @(negedge clk);
        ii_valid = 1'b1; ii_data = 18'hA1; sii_valid = 1'b1; sii_data = 26'h1A1;
        dout_ready = 1'b0;
        @(negedge clk);
        ii_data = 18'hA2; sii_data = 26'h1A2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_dv", dout_valid, 1'b1);
            check("bp_ii", dout_ii, 18'hA1);
            check("bp_sii", dout_sii, 26'h1A1);
            check("bp_ir", ii_ready, 1'b0);
            check("bp_sr", sii_ready, 1'b0);
            ii_data = 18'hA3; sii_data = 26'h1A3;
        end
        ii_valid = 1'b0; sii_valid = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_dv", dout_valid, 1'b1);
        check("bp_rel_ii", dout_ii, 18'hA2);
        check("bp_rel_sii", dout_sii, 26'h1A2);
        check("bp_rel_pix", pix_cnt, 16'd5);
        @(negedge clk);
        check("bp_done_dv", dout_valid, 1'b0);
        check("bp_done_pix", pix_cnt, 16'd6);

        // Asynchronous reset with two pairs buffered
        dout_ready = 1'b0;
        ii_valid = 1'b1; ii_data = 18'hB1; sii_valid = 1'b1; sii_data = 26'h1B1;
        @(negedge clk);
        ii_data = 18'hB2; sii_data = 26'h1B2;
        @(negedge clk);
        ii_valid = 1'b0; sii_valid = 1'b0;
        check("prerst_dv", dout_valid, 1'b1);
        check("prerst_full", ii_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_dv", dout_valid, 1'b0);
        check("arst_ir", ii_ready, 1'b1);
        check("arst_sr", sii_ready, 1'b1);
        check("arst_pix", pix_cnt, 16'd0);
        check("arst_row", row_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        check("postrst_dv", dout_valid, 1'b0);

        // Row of 24 pixels, last marked end-of-row
        for (int p = 0; p < 23; p++) begin
            xfer(18'h100 + 18'(p), 26'h2000 + 26'(p), 2'b00, 2'b00);
        end
        check("row_pix23", pix_cnt, 16'd23);
        check("row_row0", row_cnt, 16'd0);
        xfer(18'h117, 26'h2017, 2'b01, 2'b01);
        check("eor_pix", pix_cnt, 16'd0);
        check("eor_row", row_cnt, 16'd1);
        for (int p = 0; p < 3; p++) begin
            xfer(18'h200 + 18'(p), 26'h3000 + 26'(p), 2'b00, 2'b00);
        end
        check("r1_pix3", pix_cnt, 16'd3);
        check("r1_row1", row_cnt, 16'd1);
        xfer(18'h203, 26'h3003, 2'b11, 2'b11);
        check("eof_pix", pix_cnt, 16'd0);
        check("eof_row", row_cnt, 16'd0);
        check("eof_err", err_eot, 1'b0);

        // eot disagreement between the streams
        xfer(18'h300, 26'h4000, 2'b01, 2'b00);
        check("mis_err", err_eot, ERR_EXP);
        check("mis_row", row_cnt, 16'd1);
        xfer(18'h301, 26'h4001, 2'b00, 2'b00);
        check("mis_err_held", err_eot, ERR_EXP);
        check("mis_pix", pix_cnt, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mis_err_rst", err_eot, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("end_err", err_eot, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
